// File: rtl/buck_softstart_sequencer.sv
// Soft-start sequencer for the buck voltage loop: ramps the PID setpoint, paces the ADC, qualifies power-good and latches OV faults.
// Optional macro SEQ_UV_FAULT_EN adds an under-voltage trip while regulating with power-good asserted.
module buck_softstart_sequencer #(
  parameter int unsigned           DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] TARGET     = 12'd2048,
  parameter logic [DATA_WIDTH-1:0] RAMP_STEP  = 12'd8,
  parameter logic [15:0]           RAMP_DIV   = 16'd1000,
  parameter logic [15:0]           SAMPLE_DIV = 16'd100,
  parameter logic [DATA_WIDTH-1:0] OV_LIMIT   = 12'd2600,
  parameter logic [DATA_WIDTH-1:0] PG_WINDOW  = 12'd64,
  parameter logic [7:0]            PG_COUNT   = 8'd16,
  parameter logic [15:0]           FAULT_HOLD = 16'd50000,
  parameter logic [DATA_WIDTH-1:0] UV_LIMIT   = 12'd1800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fault_clear,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  adc_valid,
  output logic                  adc_start,
  output logic [DATA_WIDTH-1:0] setpoint,
  output logic                  pid_enable,
  output logic                  pwm_enable,
  output logic                  power_good,
  output logic                  fault,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    REGULATE = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t                cur, nxt;
  logic [15:0]           samp_cnt;
  logic [15:0]           ramp_cnt, ramp_cnt_n;
  logic [15:0]           hold_cnt, hold_cnt_n;
  logic [7:0]            pg_cnt, pg_cnt_n;
  logic [DATA_WIDTH-1:0] setpoint_n;
  logic [DATA_WIDTH:0]   ramp_sum;
  logic [DATA_WIDTH-1:0] abs_err;
  logic                  in_band, ov_trip, uv_trip, hold_expired, ramp_tick;

  assign abs_err      = (adc_data >= TARGET) ? (adc_data - TARGET) : (TARGET - adc_data);
  assign in_band      = (abs_err <= PG_WINDOW);
  assign ov_trip      = adc_valid && (adc_data > OV_LIMIT);
  assign hold_expired = (hold_cnt == FAULT_HOLD - 16'd1);
  assign ramp_tick    = (ramp_cnt == RAMP_DIV - 16'd1);
  // Extra headroom bit keeps the ramp from wrapping past full scale before clamping.
  assign ramp_sum     = {1'b0, setpoint} + {1'b0, RAMP_STEP};

`ifdef SEQ_UV_FAULT_EN
  assign uv_trip = (cur == REGULATE) && power_good && adc_valid && (adc_data < UV_LIMIT);
`else
  logic unused_uv_limit;
  assign unused_uv_limit = ^UV_LIMIT;
  assign uv_trip = 1'b0;
`endif

  always_comb begin
    nxt        = cur;
    ramp_cnt_n = ramp_cnt;
    pg_cnt_n   = pg_cnt;
    setpoint_n = setpoint;
    hold_cnt_n = '0;
    case (cur)
      IDLE: begin
        ramp_cnt_n = '0;
        pg_cnt_n   = '0;
        setpoint_n = '0;
        if (enable) nxt = RAMP;
      end
      RAMP: begin
        ramp_cnt_n = ramp_tick ? 16'd0 : ramp_cnt + 16'd1;
        if (ramp_tick)
          setpoint_n = (ramp_sum > {1'b0, TARGET}) ? TARGET : ramp_sum[DATA_WIDTH-1:0];
        if (ov_trip)                nxt = FAULT;
        else if (!enable)           nxt = IDLE;
        else if (setpoint == TARGET) nxt = REGULATE;
      end
      REGULATE: begin
        setpoint_n = TARGET;
        if (adc_valid) begin
          if (!in_band)                pg_cnt_n = '0;
          else if (pg_cnt != PG_COUNT) pg_cnt_n = pg_cnt + 8'd1;
        end
        if (ov_trip || uv_trip) nxt = FAULT;
        else if (!enable)       nxt = IDLE;
      end
      FAULT: begin
        hold_cnt_n = hold_expired ? hold_cnt : hold_cnt + 16'd1;
        if (hold_expired && fault_clear) nxt = IDLE;
      end
    endcase
    // Shutdown and fault entry drop the setpoint and qualification on the same edge.
    if (nxt == IDLE || nxt == FAULT) begin
      setpoint_n = '0;
      pg_cnt_n   = '0;
      ramp_cnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= IDLE;
      samp_cnt   <= '0;
      ramp_cnt   <= '0;
      hold_cnt   <= '0;
      pg_cnt     <= '0;
      adc_start  <= 1'b0;
      setpoint   <= '0;
      pid_enable <= 1'b0;
      pwm_enable <= 1'b0;
      power_good <= 1'b0;
      fault      <= 1'b0;
    end else begin
      cur        <= nxt;
      samp_cnt   <= (samp_cnt == SAMPLE_DIV - 16'd1) ? 16'd0 : samp_cnt + 16'd1;
      adc_start  <= (samp_cnt == SAMPLE_DIV - 16'd2);
      ramp_cnt   <= ramp_cnt_n;
      hold_cnt   <= hold_cnt_n;
      pg_cnt     <= pg_cnt_n;
      setpoint   <= setpoint_n;
      pid_enable <= (nxt == RAMP) || (nxt == REGULATE);
      pwm_enable <= (nxt == RAMP) || (nxt == REGULATE);
      power_good <= (nxt == REGULATE) && (pg_cnt_n == PG_COUNT);
      fault      <= (nxt == FAULT);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_buck_softstart_sequencer.sv
// Scoreboard bench for buck_softstart_sequencer: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_buck_softstart_sequencer;

  localparam int TGT   = 2000;
  localparam int STEP  = 512;
  localparam int RDIV  = 4;
  localparam int SDIV  = 4;
  localparam int OVL   = 2600;
  localparam int PGW   = 64;
  localparam int PGC   = 3;
  localparam int FHOLD = 10;
  localparam int UVL   = 1800;

  localparam int S_IDLE = 0, S_RAMP = 1, S_REG = 2, S_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fault_clear = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        adc_start;
  logic [11:0] setpoint;
  logic        pid_enable, pwm_enable, power_good, fault;
  logic [1:0]  state;

  buck_softstart_sequencer #(
    .DATA_WIDTH(12), .TARGET(12'd2000), .RAMP_STEP(12'd512), .RAMP_DIV(16'd4),
    .SAMPLE_DIV(16'd4), .OV_LIMIT(12'd2600), .PG_WINDOW(12'd64), .PG_COUNT(8'd3),
    .FAULT_HOLD(16'd10), .UV_LIMIT(12'd1800)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fault_clear(fault_clear),
    .adc_data(adc_data), .adc_valid(adc_valid), .adc_start(adc_start),
    .setpoint(setpoint), .pid_enable(pid_enable), .pwm_enable(pwm_enable),
    .power_good(power_good), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [18:0] v;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  int stim_timeouts = 0;
  bit done = 1'b0;

  // Reference model: time-based view of the sequence.
  int m_state = S_IDLE;
  int m_t = 0;     // cycles since reset release
  int m_age = 0;   // cycles spent in the current ramp
  int m_fage = 0;  // cycles spent in the current fault
  int m_pg = 0;    // consecutive in-band samples, saturating

  function automatic int model_sp();
    int s;
    if (m_state == S_REG) return TGT;
    if (m_state != S_RAMP) return 0;
    s = STEP * (m_age / RDIV);
    return (s > TGT) ? TGT : s;
  endfunction

  function automatic logic [18:0] model_out();
    logic [11:0] spv;
    logic [1:0]  st;
    logic        run;
    spv = 12'(model_sp());
    st  = 2'(m_state);
    run = (m_state == S_RAMP) || (m_state == S_REG);
    return {(m_t % SDIV) == SDIV - 1, spv, run, run,
            (m_state == S_REG) && (m_pg >= PGC), m_state == S_FAULT, st};
  endfunction

  task automatic model_edge(input logic r, input logic en, input logic fc,
                            input logic v, input logic [11:0] d);
    bit ov, uv;
    int err;
    if (r) begin
      m_state = S_IDLE; m_t = 0; m_age = 0; m_fage = 0; m_pg = 0;
      return;
    end
    m_t++;
    ov  = v && (int'(d) > OVL);
    err = int'(d) - TGT;
    if (err < 0) err = -err;
    case (m_state)
      S_IDLE: if (en) begin m_state = S_RAMP; m_age = 0; end
      S_RAMP: begin
        if (ov)                    begin m_state = S_FAULT; m_fage = 0; m_pg = 0; end
        else if (!en)              m_state = S_IDLE;
        else if (model_sp() == TGT) begin m_state = S_REG; m_pg = 0; end
        else                       m_age++;
      end
      S_REG: begin
`ifdef SEQ_UV_FAULT_EN
        uv = v && (int'(d) < UVL) && (m_pg >= PGC);
`else
        uv = 1'b0;
`endif
        if (v) m_pg = (err <= PGW) ? ((m_pg + 1 > PGC) ? PGC : m_pg + 1) : 0;
        if (ov || uv)  begin m_state = S_FAULT; m_fage = 0; m_pg = 0; end
        else if (!en)  begin m_state = S_IDLE; m_pg = 0; end
      end
      default: begin
        if (m_fage >= FHOLD - 1 && fc) m_state = S_IDLE;
        else m_fage++;
      end
    endcase
  endtask

  task automatic step(input logic r, input logic en, input logic fc,
                      input logic v, input logic [11:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; enable = en; fault_clear = fc; adc_valid = v; adc_data = d;
    model_edge(r, en, fc, v, d);
    e.cyc = cyc + 1;
    e.v   = model_out();
    sbq.push_back(e);
  endtask

  // Drive towards REGULATE from any state, acknowledging faults on the way.
  task automatic goto_reg();
    int n;
    n = 0;
    while (m_state != S_REG && n < 200) begin
      step(0, 1, m_state == S_FAULT, 0, 12'd0);
      n++;
    end
    if (m_state != S_REG) stim_timeouts++;
  endtask

  function automatic logic [11:0] rand_dat();
    int p;
    p = $urandom_range(99);
    if (p < 70) return 12'(TGT - 80 + $urandom_range(160));
    if (p < 80) return 12'(OVL + 1 + $urandom_range(300));
    return 12'($urandom_range(4095));
  endfunction

  initial begin : stim
    logic en_r;
    repeat (3) step(1, 0, 0, 0, 12'd0);
    // OV-level samples are ignored while idle
    for (int i = 0; i < 14; i++) step(0, 0, 0, (i % 3) == 0, 12'd3000);
    goto_reg();
    // power-good qualification, then loss on an out-of-band sample
    step(0, 1, 0, 1, 12'd2000); step(0, 1, 0, 0, 12'd0);
    step(0, 1, 0, 1, 12'd2060); step(0, 1, 0, 1, 12'd1940);
    step(0, 1, 0, 0, 12'd0);    step(0, 1, 0, 1, 12'd2100);
    step(0, 1, 0, 0, 12'd0);
    // regain power-good, then an under-voltage sample
    repeat (3) step(0, 1, 0, 1, 12'd2010);
    step(0, 1, 0, 1, 12'd1700);
    repeat (4) step(0, 1, 0, 0, 12'd0);
    // OV on the same cycle enable falls; clear held from entry
    goto_reg();
    step(0, 0, 1, 1, 12'd2601);
    for (int i = 0; i < 14; i++) step(0, i < 6, 1, 0, 12'd0);
    // an early clear is not remembered
    goto_reg();
    step(0, 1, 0, 1, 12'd2700);
    repeat (5) step(0, 1, 1, 0, 12'd0);
    repeat (6) step(0, 1, 0, 0, 12'd0);
    repeat (3) step(0, 1, 1, 0, 12'd0);
    // shutdown mid-ramp and restart from zero
    repeat (2) step(0, 0, 0, 0, 12'd0);
    repeat (7) step(0, 1, 0, 0, 12'd0);
    step(0, 0, 0, 0, 12'd0);
    goto_reg();
    // reset in the middle of a fault hold
    step(0, 1, 0, 1, 12'd4000);
    repeat (4) step(0, 1, 1, 0, 12'd0);
    step(1, 1, 1, 0, 12'd0);
    repeat (6) step(0, 1, 0, 0, 12'd0);
    // randomized traffic
    en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(59) == 0) en_r = ~en_r;
      step($urandom_range(299) == 0, en_r, $urandom_range(3) == 0,
           $urandom_range(2) == 0, rand_dat());
    end
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  initial begin : monitor
    exp_t        e;
    logic [18:0] a;
    while (!done) begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checks++; failures++;
        $display("FAIL stale_expectation cyc=%0d actual=unchecked required=compared", e.cyc);
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        a = {adc_start, setpoint, pid_enable, pwm_enable, power_good, fault, state};
        checks++;
        if (a !== e.v) begin
          failures++;
          $display("FAIL outputs cyc=%0d actual start=%0b sp=%0d pid=%0b pwm=%0b pg=%0b flt=%0b st=%0d required start=%0b sp=%0d pid=%0b pwm=%0b pg=%0b flt=%0b st=%0d",
                   cyc, a[18], a[17:6], a[5], a[4], a[3], a[2], a[1:0],
                   e.v[18], e.v[17:6], e.v[5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    checks++;
    if (stim_timeouts != 0) begin
      failures++;
      $display("FAIL reach_regulate_timeout actual=%0d required=0", stim_timeouts);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
